thermo_sample_ctrl: RTL
=======================

// Module: thermo_sample_ctrl
// PURPOSE
//  Sequencer between the temperature sensor front end and the hot/normal/cold classifier.
//  Triggers periodic sensor reads over a req/ack handshake and averages NUM_SAMPLES readings.
//  Classifies each average into hot/normal/cold (optional hysteresis) and flags sensor timeouts and missed sample ticks.
// PARAMETERS
//  SAMPLE_PERIOD  1000  clk cycles between sample ticks (>=2)
//  LOG2_N         2     log2 of samples averaged per window (NUM_SAMPLES = 4)
//  TIMEOUT        64    max cycles in REQ waiting for sensor_ack
//  HOT_TH         8'd40 avg > HOT_TH -> hot
//  COLD_TH        8'd20 avg < COLD_TH -> cold
//  HYST           8'd2  hysteresis band; must satisfy HYST <= COLD_TH and HOT_TH+HYST <= 255
// PORTS
//  clk          in   1  clock, rising edge
//  rst_n        in   1  asynchronous, active-low reset
//  enable       in   1  1 = run sample timer
//  sensor_req   out  1  read request to sensor
//  sensor_ack   in   1  sensor_data valid when high
//  sensor_data  in   8  unsigned temperature, deg C
//  temp_avg     out  8  last window average
//  avg_valid    out  1  1-cycle pulse, temp_avg/status just updated
//  hot/normal/cold out 1 each, one-hot once classified
//  sensor_fault out  1  set on timeout, cleared on next accepted ack
//  overrun      out  1  sticky: tick arrived while not IDLE
// BEHAVIOUR
//  Reset: all outputs 0; FSM=IDLE; tick counter, sample count, accumulator = 0.
//  Tick counter counts 0..SAMPLE_PERIOD-1 while enable=1, wraps; tick = (cnt==SAMPLE_PERIOD-1).
//  enable=0: counter held at 0, no new ticks; in-flight REQ completes normally; partial window kept.
//  FSM IDLE: tick -> REQ (sensor_req=1 next cycle). Tick while in REQ/UPDATE: ignored, overrun<=1.
//  REQ: sensor_req held 1 until ack sampled; ack accepted only in REQ; ack outside REQ ignored.
//   On ack: acc += sensor_data, sample_cnt++, sensor_fault<=0, sensor_req<=0 next cycle.
//   Last sample (sample_cnt==2^LOG2_N-1) -> UPDATE, else -> IDLE.
//   Wait counter reaches TIMEOUT with no ack -> sensor_fault<=1, acc/sample_cnt cleared
//   (partial window discarded), sensor_req<=0, -> IDLE. Ack and timeout same cycle: ack wins.
//  UPDATE (1 cycle): temp_avg <= acc >> LOG2_N (truncate); accumulator width 8+LOG2_N,
//   no overflow possible; classify avg; avg_valid=1 that cycle; acc, cnt cleared; -> IDLE.
//  Latency: avg_valid and status asserted 2 clk after the cycle the final ack is sampled.
//  Classification (plain): avg>HOT_TH hot; avg<COLD_TH cold; else normal. Exactly one high.
//  Status only changes on avg_valid; held between windows.
//  No status yet (all 0) at first window: always plain compare.
// CONFIGURATION
//  THERMO_HYST_EN defined: status transitions use hysteresis from current status:
//   HOT stays until avg <= HOT_TH-HYST -> then re-evaluate (cold if avg<COLD_TH, else normal).
//   COLD stays until avg >= COLD_TH+HYST -> then re-evaluate (hot if avg>HOT_TH, else normal).
//   NORMAL: plain compare.
//  THERMO_HYST_EN undefined: plain compare every window; HYST unused.
// TESTING
//  1 Reset mid-REQ (sensor_req=1): rst_n low -> all outputs 0 asynchronously; resume at IDLE.
//  2 4 acks data 40,41,42,43 -> temp_avg=41, hot=1, avg_valid one pulse 2 clk after 4th ack.
//  3 Data 10,10,10,11 -> acc=41, temp_avg=10 (truncate), cold=1; 20,20,20,20 -> normal=1.
//  4 No ack for 64 cycles after 2 good samples -> sensor_fault=1, sensor_req drops, window
//    restarts; next 4 acks of 30 -> temp_avg=30, sensor_fault cleared on first ack.
//  5 SAMPLE_PERIOD=4, sensor acks after 10 cycles -> overrun=1 and stays 1; ack in IDLE ignored.
//  6 THERMO_HYST_EN: hot (avg 45), next avg 39 -> hot held; next avg 38 -> normal;
//    without macro avg 39 -> normal.

Source files
------------

// File: rtl/thermo_sample_ctrl.sv
// Sensor read sequencer: periodic req/ack sampling, window averaging and hot/normal/cold classification.
// Optional macro THERMO_HYST_EN adds hysteresis (and the HYST parameter) to status transitions.
module thermo_sample_ctrl #(
  parameter int unsigned SAMPLE_PERIOD = 1000,
  parameter int unsigned LOG2_N        = 2,
  parameter int unsigned TIMEOUT       = 64,
  parameter logic [7:0]  HOT_TH        = 8'd40,
  parameter logic [7:0]  COLD_TH       = 8'd20
`ifdef THERMO_HYST_EN
  ,
  parameter logic [7:0]  HYST          = 8'd2
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable_i,
  output logic       sensor_req_o,
  input  logic       sensor_ack_i,
  input  logic [7:0] sensor_data_i,
  output logic [7:0] temp_avg_o,
  output logic       avg_valid_o,
  output logic       hot_o,
  output logic       normal_o,
  output logic       cold_o,
  output logic       sensor_fault_o,
  output logic       overrun_o
);

  localparam int CNT_W  = (SAMPLE_PERIOD > 2) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam int SCNT_W = (LOG2_N > 0) ? LOG2_N : 1;
  localparam int ACC_W  = 8 + LOG2_N;

  localparam logic [2:0] ST_HOT    = 3'b100;
  localparam logic [2:0] ST_NORMAL = 3'b010;
  localparam logic [2:0] ST_COLD   = 3'b001;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REQ    = 2'd1,
    S_UPDATE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    tick_cnt_q, tick_cnt_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [SCNT_W-1:0]   scnt_q, scnt_d;
  logic [7:0]          temp_avg_q, temp_avg_d;
  logic                avg_valid_q, avg_valid_d;
  logic [2:0]          status_q, status_d;
  logic                fault_q, fault_d;
  logic                overrun_q, overrun_d;
  logic                tick;
  logic [7:0]          avg_w;

  function automatic logic [2:0] classify_plain(input logic [7:0] avg);
    if (avg > HOT_TH)       return ST_HOT;
    else if (avg < COLD_TH) return ST_COLD;
    else                    return ST_NORMAL;
  endfunction

`ifdef THERMO_HYST_EN
  // Hot/cold persist until the average leaves the band; then a plain compare decides.
  function automatic logic [2:0] classify_hyst(input logic [7:0] avg, input logic [2:0] cur);
    if (cur == ST_HOT  && avg > (HOT_TH - HYST))  return ST_HOT;
    if (cur == ST_COLD && avg < (COLD_TH + HYST)) return ST_COLD;
    return classify_plain(avg);
  endfunction
`endif

  assign tick  = enable_i && (tick_cnt_q == CNT_W'(SAMPLE_PERIOD - 1));
  assign avg_w = 8'(acc_q >> LOG2_N);

  always_comb begin
    state_d     = state_q;
    tick_cnt_d  = tick_cnt_q;
    wait_d      = wait_q;
    acc_d       = acc_q;
    scnt_d      = scnt_q;
    temp_avg_d  = temp_avg_q;
    avg_valid_d = 1'b0;
    status_d    = status_q;
    fault_d     = fault_q;
    overrun_d   = overrun_q;

    if (!enable_i || tick) tick_cnt_d = '0;
    else                   tick_cnt_d = tick_cnt_q + CNT_W'(1);

    case (state_q)
      S_IDLE: begin
        wait_d = '0;
        if (tick) state_d = S_REQ;
      end
      S_REQ: begin
        if (tick) overrun_d = 1'b1;
        // An ack in the timeout cycle still counts as a good sample.
        if (sensor_ack_i) begin
          acc_d   = acc_q + ACC_W'(sensor_data_i);
          scnt_d  = scnt_q + SCNT_W'(1);
          fault_d = 1'b0;
          wait_d  = '0;
          state_d = (scnt_q == {SCNT_W{1'b1}}) ? S_UPDATE : S_IDLE;
        end else if (wait_q == WAIT_W'(TIMEOUT - 1)) begin
          fault_d = 1'b1;
          acc_d   = '0;
          scnt_d  = '0;
          wait_d  = '0;
          state_d = S_IDLE;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_UPDATE: begin
        if (tick) overrun_d = 1'b1;
        temp_avg_d  = avg_w;
`ifdef THERMO_HYST_EN
        status_d    = classify_hyst(avg_w, status_q);
`else
        status_d    = classify_plain(avg_w);
`endif
        avg_valid_d = 1'b1;
        acc_d       = '0;
        scnt_d      = '0;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      tick_cnt_q  <= '0;
      wait_q      <= '0;
      acc_q       <= '0;
      scnt_q      <= '0;
      temp_avg_q  <= '0;
      avg_valid_q <= 1'b0;
      status_q    <= '0;
      fault_q     <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      wait_q      <= wait_d;
      acc_q       <= acc_d;
      scnt_q      <= scnt_d;
      temp_avg_q  <= temp_avg_d;
      avg_valid_q <= avg_valid_d;
      status_q    <= status_d;
      fault_q     <= fault_d;
      overrun_q   <= overrun_d;
    end
  end

  assign sensor_req_o   = (state_q == S_REQ);
  assign temp_avg_o     = temp_avg_q;
  assign avg_valid_o    = avg_valid_q;
  assign hot_o          = status_q[2];
  assign normal_o       = status_q[1];
  assign cold_o         = status_q[0];
  assign sensor_fault_o = fault_q;
  assign overrun_o      = overrun_q;

endmodule
